// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
// Imported by mem_port_arbiter and its timeout counter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [31:0] ABORT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_cnt.sv
// BUSY-cycle watchdog for the arbiter; built only with MEM_ARB_TIMEOUT_EN.
// expired is a flop so the abort lines up with the LIMIT-th BUSY cycle.
module arb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          exp_q, exp_d;

  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    if (clr) begin
      cnt_d = '0;
      exp_d = 1'b0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
      // count is about to reach LIMIT-1
      exp_d = (cnt_q == CW'(LIMIT - 2));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired = exp_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and load/store (D).
// Define MEM_ARB_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES with arb_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            arb_err
);

  arb_state_e      state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0] mem_be_q, mem_be_d;

  logic busy, abort, done;
  logic grant_i, grant_d;
  logic [DW-1:0] rdata;

  assign busy = (state_q != ARB_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;

  arb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy),
    .inc     (busy && !mem_ready && !expired),
    .expired (expired)
  );

  assign abort = busy && expired;
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
  assign abort      = 1'b0;
`endif

  assign done    = busy && (mem_ready || abort);
  assign grant_i = i_req && (!d_req || last_grant_q == GRANT_D);
  assign grant_d = d_req && !grant_i;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if (state_q == ARB_IDLE) begin
      unique case (1'b1)
        grant_i: begin
          state_d      = ARB_BUSY_I;
          last_grant_d = GRANT_I;
          mem_we_d     = 1'b0;
          mem_addr_d   = i_addr;
          mem_wdata_d  = '0;
          mem_be_d     = '1;
        end
        grant_d: begin
          state_d      = ARB_BUSY_D;
          last_grant_d = GRANT_D;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_be_d     = d_be;
        end
        default: ;
      endcase
    end else if (done) begin
      state_d = ARB_IDLE;
    end
    mem_req_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_D;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  // a transaction cut by reset must never ack
  assign i_ack = rst && done && (state_q == ARB_BUSY_I);
  assign d_ack = rst && done && (state_q == ARB_BUSY_D);

  assign rdata   = abort ? DW'(ABORT_RDATA) : mem_rdata;
  assign i_rdata = rdata;
  assign d_rdata = rdata;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign arb_err   = abort;

endmodule
